pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush/forward controller for the 5-stage pipeline (IFID, IDEXE, EXEMEM, MEMWB registers).
//  Detects RAW hazards, drives forwarding muxes in ID and EX, and sequences multi-cycle data-memory accesses.
//  A req/ack FSM with timeout handles memory; exceptions and bus errors flush the pipeline.
// PARAMETERS
//  MEM_TIMEOUT  64  max cycles waiting for DMem_Ack before bus error (>=2)
//  CNT_WIDTH    16  width of saturating stall-cycle counter
// PORTS
//  clk  in 1  clock; all state updates on posedge
//  rst  in 1  synchronous reset, active-high
//  ID_Rs/ID_Rt  in 5 each  source regs of instruction in ID
//  ID_NeedRs/ID_NeedRt  in 1 each  operand consumed in ID (branch compare)
//  ID_WantRsByEX/ID_WantRtByEX  in 1 each  operand consumed in EX
//  EX_Rs/EX_Rt  in 5 each  source regs of instruction in EX
//  EX_RtRd  in 5  EX destination;  EX_RegWrite in 1;  EX_MemRead in 1
//  M_RtRd  in 5  MEM destination;  M_RegWrite in 1;  M_MemRead in 1;  M_MemWrite in 1
//  WB_RtRd  in 5  WB destination;  WB_RegWrite in 1
//  M_Exception  in 1  exception raised by instruction in MEM
//  DMem_Ack  in 1  data memory completion strobe
//  DMem_Req  out 1  data memory request, held high while WAIT
//  IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall  out 1 each
//  IF_Flush, ID_Flush, EX_Flush, M_Flush  out 1 each
//  ID_RsFwdSel/ID_RtFwdSel  out 2 each  00 regfile, 01 M_ALU_Result, 10 WB data
//  EX_RsFwdSel/EX_RtFwdSel  out 2 each  00 IDEXE value, 01 M_ALU_Result, 10 WB data
//  BusErr  out 1  one-cycle pulse on memory timeout
//  StallCount  out CNT_WIDTH  saturating count of cycles with IF_Stall=1
// BEHAVIOUR
//  Reset: FSM=IDLE, timer=0, StallCount=0, BusErr=0; all stalls/flushes/DMem_Req/FwdSel = 0.
//  Match(a,b,we) = we & (a==b) & (a!=0); register 0 never causes a stall or forward.
//  ID hazard (ID_Stall=IF_Stall=1, EX_Stall=0 => bubble into EX), any of:
//   - NeedRs/Rt & Match(ID_Rx, EX_RtRd, EX_RegWrite)
//   - NeedRs/Rt & Match(ID_Rx, M_RtRd, M_RegWrite) & M_MemRead
//   - WantRs/RtByEX & Match(ID_Rx, EX_RtRd, EX_RegWrite) & EX_MemRead (load-use)
//  Forwarding (combinational): M match beats WB match; M forward only if !M_MemRead; else 00.
//  Mem FSM states IDLE, WAIT, DONE:
//   - IDLE: M_MemRead|M_MemWrite and no flush -> WAIT, timer=0.
//   - WAIT: DMem_Req=1; M/EX/ID/IF_Stall=1, WB_Stall=0 (bubble into WB); timer++.
//     DMem_Ack -> DONE. timer==MEM_TIMEOUT-1 without Ack -> IDLE, BusErr=1 for 1 cycle.
//   - DONE: stalls released for one cycle so the access retires; -> IDLE unconditionally.
//   - Ack in the same cycle as the timeout limit counts as success (DONE, no BusErr).
//  Flush: M_Exception or BusErr asserts IF/ID/EX/M_Flush for exactly that cycle; stalls are forced
//   to 0 that cycle; FSM aborts to IDLE; DMem_Req drops at once.
//  Stall priority: mem wait overrides ID hazard; upstream stages always stall when downstream does.
//  Branches do not flush (delay slot is architectural).
//  StallCount += 1 per IF_Stall cycle; holds at 2^CNT_WIDTH-1.
//  Reset mid-WAIT: next cycle IDLE, DMem_Req=0, outputs at reset values.
//  Latency: hazard stalls combinational (same cycle); mem stall from cycle after access enters MEM
//   until Ack cycle inclusive.
// TESTING
//  EX lw r5 (EX_MemRead), ID add Rs=r5 WantRsByEX -> ID_Stall=IF_Stall=1, EX_Stall=0 one cycle.
//  M writes r3 (ALU), WB writes r3, EX reads r3 -> EX_RsFwdSel=01; M dest r0 -> 00, no stall.
//  Store enters MEM, Ack after 3 WAIT cycles -> DMem_Req 3 cycles, M_Stall 3 cycles, WB_Stall=0.
//  No Ack, MEM_TIMEOUT=8 -> BusErr pulse in 8th WAIT cycle, IF..M_Flush=1 that cycle, FSM IDLE.
//  M_Exception during WAIT -> flushes 1 cycle, DMem_Req=0 next edge; rst mid-WAIT -> all outputs 0.
//  Hold IF_Stall 70000 cycles with CNT_WIDTH=16 -> StallCount saturates at 65535.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for a 5-stage pipeline, including the
// req/ack sequencer with timeout for multi-cycle data-memory accesses.
//
// state   | meaning
// IDLE    | no access outstanding; a load/store arriving in MEM starts one
// WAIT    | DMem_Req high, IF..MEM frozen, WB takes bubbles until DMem_Ack
// DONE    | stalls released for one cycle so the access retires
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 ID_NeedRs,
  input  logic                 ID_NeedRt,
  input  logic                 ID_WantRsByEX,
  input  logic                 ID_WantRtByEX,
  input  logic [4:0]           EX_Rs,
  input  logic [4:0]           EX_Rt,
  input  logic [4:0]           EX_RtRd,
  input  logic                 EX_RegWrite,
  input  logic                 EX_MemRead,
  input  logic [4:0]           M_RtRd,
  input  logic                 M_RegWrite,
  input  logic                 M_MemRead,
  input  logic                 M_MemWrite,
  input  logic [4:0]           WB_RtRd,
  input  logic                 WB_RegWrite,
  input  logic                 M_Exception,
  input  logic                 DMem_Ack,
  output logic                 DMem_Req,
  output logic                 IF_Stall,
  output logic                 ID_Stall,
  output logic                 EX_Stall,
  output logic                 M_Stall,
  output logic                 WB_Stall,
  output logic                 IF_Flush,
  output logic                 ID_Flush,
  output logic                 EX_Flush,
  output logic                 M_Flush,
  output logic [1:0]           ID_RsFwdSel,
  output logic [1:0]           ID_RtFwdSel,
  output logic [1:0]           EX_RsFwdSel,
  output logic [1:0]           EX_RtFwdSel,
  output logic                 BusErr,
  output logic [CNT_WIDTH-1:0] StallCount
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} mem_state_e;

  mem_state_e           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic bus_err, flush, mem_wait, id_haz, if_stall;

  function automatic logic match(input logic [4:0] a, input logic [4:0] b, input logic we);
    return we && (a == b) && (a != 5'd0);
  endfunction

  // The youngest producer wins; a load still in MEM has no value to forward yet.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (match(src, M_RtRd, M_RegWrite)) return M_MemRead ? 2'b00 : 2'b01;
    if (match(src, WB_RtRd, WB_RegWrite)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic src_haz(input logic [4:0] src, input logic need, input logic want_ex);
    return (need && match(src, EX_RtRd, EX_RegWrite))
        || (need && match(src, M_RtRd, M_RegWrite) && M_MemRead)
        || (want_ex && match(src, EX_RtRd, EX_RegWrite) && EX_MemRead);
  endfunction

  always_comb begin
    // Down-counter: loaded on entry to WAIT, terminal count 0 is the last allowed cycle.
    bus_err  = !rst && (state_q == ST_WAIT) && !DMem_Ack && (timer_q == '0);
    flush    = !rst && (M_Exception || bus_err);
    mem_wait = !rst && !flush && (state_q == ST_WAIT);
    id_haz   = src_haz(ID_Rs, ID_NeedRs, ID_WantRsByEX)
            || src_haz(ID_Rt, ID_NeedRt, ID_WantRtByEX);
    if_stall = !rst && !flush && (mem_wait || id_haz);

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if ((M_MemRead || M_MemWrite) && !flush) begin
          state_d = ST_WAIT;
          timer_d = TIMER_LOAD;
        end
      end
      ST_WAIT: begin
        if (flush)         state_d = ST_IDLE;
        else if (DMem_Ack) state_d = ST_DONE;
        else               timer_d = timer_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (if_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    DMem_Req    = mem_wait;
    IF_Stall    = if_stall;
    ID_Stall    = if_stall;
    EX_Stall    = mem_wait;
    M_Stall     = mem_wait;
    WB_Stall    = 1'b0;
    IF_Flush    = flush;
    ID_Flush    = flush;
    EX_Flush    = flush;
    M_Flush     = flush;
    BusErr      = bus_err;
    ID_RsFwdSel = rst ? 2'b00 : fwd_sel(ID_Rs);
    ID_RtFwdSel = rst ? 2'b00 : fwd_sel(ID_Rt);
    EX_RsFwdSel = rst ? 2'b00 : fwd_sel(EX_Rs);
    EX_RtFwdSel = rst ? 2'b00 : fwd_sel(EX_Rt);
    StallCount  = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded bench for pipeline_hazard_ctrl: hazards, forwarding, memory
// sequencing, timeout, flushes, reset mid-access and stall-counter saturation.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, M_RtRd, WB_RtRd;
  logic        ID_NeedRs, ID_NeedRt, ID_WantRsByEX, ID_WantRtByEX;
  logic        EX_RegWrite, EX_MemRead, M_RegWrite, M_MemRead, M_MemWrite, WB_RegWrite;
  logic        M_Exception, DMem_Ack;
  logic        DMem_Req, IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall;
  logic        IF_Flush, ID_Flush, EX_Flush, M_Flush, BusErr;
  logic [1:0]  ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel;
  logic [15:0] StallCount;

  int          n_checks = 0;
  int          n_errors = 0;
  int          model_cnt = 0;
  logic [18:0] exp_q[$];

  // {DMem_Req, IF..WB_Stall, IF..M_Flush, BusErr, ID_Rs, ID_Rt, EX_Rs, EX_Rt fwd}
  localparam logic [18:0] E_NONE   = 19'd0;
  localparam logic [18:0] E_HAZ    = {1'b0, 5'b11000, 4'b0000, 1'b0, 8'h00};
  localparam logic [18:0] E_WAIT   = {1'b1, 5'b11110, 4'b0000, 1'b0, 8'h00};
  localparam logic [18:0] E_FLUSH  = {1'b0, 5'b00000, 4'b1111, 1'b0, 8'h00};
  localparam logic [18:0] E_BUSERR = {1'b0, 5'b00000, 4'b1111, 1'b1, 8'h00};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_NeedRs(ID_NeedRs), .ID_NeedRt(ID_NeedRt),
    .ID_WantRsByEX(ID_WantRsByEX), .ID_WantRtByEX(ID_WantRtByEX),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_RtRd(EX_RtRd), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .M_RtRd(M_RtRd), .M_RegWrite(M_RegWrite),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .WB_RtRd(WB_RtRd),
    .WB_RegWrite(WB_RegWrite), .M_Exception(M_Exception), .DMem_Ack(DMem_Ack),
    .DMem_Req(DMem_Req), .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall),
    .M_Stall(M_Stall), .WB_Stall(WB_Stall), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
    .EX_Flush(EX_Flush), .M_Flush(M_Flush), .ID_RsFwdSel(ID_RsFwdSel),
    .ID_RtFwdSel(ID_RtFwdSel), .EX_RsFwdSel(EX_RsFwdSel), .EX_RtFwdSel(EX_RtFwdSel),
    .BusErr(BusErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] fwdv(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c, input logic [1:0] d);
    return {11'd0, a, b, c, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ID_Rs = 0; ID_Rt = 0; EX_Rs = 0; EX_Rt = 0; EX_RtRd = 0; M_RtRd = 0; WB_RtRd = 0;
    ID_NeedRs = 0; ID_NeedRt = 0; ID_WantRsByEX = 0; ID_WantRtByEX = 0;
    EX_RegWrite = 0; EX_MemRead = 0; M_RegWrite = 0; M_MemRead = 0; M_MemWrite = 0;
    WB_RegWrite = 0; M_Exception = 0; DMem_Ack = 0;
  endtask

  task automatic load_use();
    EX_MemRead = 1; EX_RegWrite = 1; EX_RtRd = 5; ID_Rs = 5; ID_WantRsByEX = 1;
  endtask

  // Inputs are already driven for this cycle; compare at the falling edge.
  task automatic step(input string tag, input logic [18:0] exp);
    logic [18:0] e;
    logic [18:0] obs;
    exp_q.push_back(exp);
    @(negedge clk);
    obs = {DMem_Req, IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
           IF_Flush, ID_Flush, EX_Flush, M_Flush, BusErr,
           ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel};
    e = exp_q.pop_front();
    check({tag, ".out"}, 32'(obs), 32'(e));
    check({tag, ".cnt"}, 32'(StallCount), 32'(model_cnt));
    if (rst) model_cnt = 0;
    else if (e[17] && model_cnt < 65535) model_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr();
    repeat (2) @(posedge clk); #1;
    load_use();
    step("reset", E_NONE);
    rst = 0;

    clr(); load_use();                        step("load_use", E_HAZ);
    clr();                                    step("bubble", E_NONE);
    clr(); EX_RegWrite = 1; EX_RtRd = 7; ID_Rt = 7; ID_NeedRt = 1;
                                              step("need_rt_ex", E_HAZ);
    clr(); EX_RegWrite = 1; EX_RtRd = 7; ID_Rt = 7; ID_WantRtByEX = 1;
                                              step("want_rt_alu", E_NONE);
    clr(); EX_RegWrite = 1; EX_MemRead = 1; M_RegWrite = 1; ID_NeedRs = 1; ID_WantRsByEX = 1;
                                              step("r0_no_haz", E_NONE);
    clr(); M_RegWrite = 1; M_RtRd = 3; WB_RegWrite = 1; WB_RtRd = 3; EX_Rs = 3; ID_Rt = 3;
                                              step("fwd_m", fwdv(2'b00, 2'b01, 2'b01, 2'b00));
    clr(); WB_RegWrite = 1; WB_RtRd = 4; EX_Rt = 4; ID_Rs = 4;
                                              step("fwd_wb", fwdv(2'b10, 2'b00, 2'b00, 2'b10));
    clr(); M_RtRd = 3; WB_RegWrite = 1; WB_RtRd = 3; EX_Rs = 3;
                                              step("fwd_m_nowe", fwdv(2'b00, 2'b00, 2'b10, 2'b00));

    clr(); M_RegWrite = 1; M_MemRead = 1; M_RtRd = 9; ID_Rs = 9; ID_NeedRs = 1;
                                              step("need_rs_mload", E_HAZ);
    clr();                                    step("load_wait1", E_WAIT);
    DMem_Ack = 1;                             step("load_ack", E_WAIT);
    clr();                                    step("load_done", E_NONE);
                                              step("load_idle", E_NONE);

    clr(); M_MemWrite = 1;                    step("st_enter", E_NONE);
                                              step("st_w1", E_WAIT);
    load_use();                               step("st_w2_haz", E_WAIT);
    clr(); M_MemWrite = 1; DMem_Ack = 1;      step("st_w3_ack", E_WAIT);
    DMem_Ack = 0;                             step("st_done", E_NONE);
    clr();                                    step("st_idle", E_NONE);

    clr(); M_MemRead = 1;                     step("to_enter", E_NONE);
    for (int i = 1; i <= 7; i++)              step($sformatf("to_w%0d", i), E_WAIT);
                                              step("to_buserr", E_BUSERR);
    clr();                                    step("to_idle", E_NONE);

    clr(); M_MemRead = 1;                     step("lim_enter", E_NONE);
    for (int i = 1; i <= 7; i++)              step($sformatf("lim_w%0d", i), E_WAIT);
    DMem_Ack = 1;                             step("lim_ack", E_WAIT);
    DMem_Ack = 0;                             step("lim_done", E_NONE);
    clr();                                    step("lim_idle", E_NONE);

    clr(); M_MemRead = 1;                     step("exc_enter", E_NONE);
                                              step("exc_w1", E_WAIT);
    M_Exception = 1;                          step("exc_wait", E_FLUSH);
    clr();                                    step("exc_after", E_NONE);
    clr(); load_use(); M_MemRead = 1; M_Exception = 1;
                                              step("exc_idle_acc", E_FLUSH);
    clr();                                    step("exc_no_wait", E_NONE);

    clr(); M_MemRead = 1;                     step("rst_enter", E_NONE);
                                              step("rst_w1", E_WAIT);
    rst = 1; WB_RegWrite = 1; WB_RtRd = 4; EX_Rt = 4;
                                              step("rst_mid", E_NONE);
    rst = 0; clr();                           step("rst_after", E_NONE);

    clr(); EX_RegWrite = 1; EX_RtRd = 5; ID_Rs = 5; ID_NeedRs = 1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    model_cnt = (model_cnt + 70000 > 65535) ? 65535 : model_cnt + 70000;
    clr();                                    step("sat", E_NONE);
    EX_RegWrite = 1; EX_RtRd = 5; ID_Rs = 5; ID_NeedRs = 1;
                                              step("sat_haz", E_HAZ);
    clr();                                    step("sat_hold", E_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
